// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with double-buffered inputs, blink, blank and PWM dimming.
// Define SEG7_LZ_BLANK_EN to darken leading zero digits (digit 0 and digits with dp set are always shown).
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 3200,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    system_clock,
    input  logic                    cpu_rst_n,
    input  logic [4*NUM_DIGITS-1:0] display_val,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    update,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              cathodes_out,
    output logic                    dp_out,
    output logic                    frame_done
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int ON_W  = CNT_W + 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP  = SCAN_DIV >> BRIGHT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    pending_q, pending_d;
    logic                    bnd_dly_q;
    logic                    tick, boundary;

    logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d, shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d, shadow_blank_q, shadow_blank_d;
    logic [NUM_DIGITS-1:0]   stage_blink_q, stage_blink_d, shadow_blink_q, shadow_blink_d;

    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic [6:0]              cathodes_q, cathodes_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   lz_sup;
    logic [ON_W-1:0]         on_time;
    logic [3:0]              nib;
    logic                    lit;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h01;
            4'h1: seg_decode = 7'h4F;
            4'h2: seg_decode = 7'h12;
            4'h3: seg_decode = 7'h06;
            4'h4: seg_decode = 7'h4C;
            4'h5: seg_decode = 7'h24;
            4'h6: seg_decode = 7'h20;
            4'h7: seg_decode = 7'h0F;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h04;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h60;
            4'hC: seg_decode = 7'h31;
            4'hD: seg_decode = 7'h42;
            4'hE: seg_decode = 7'h30;
            default: seg_decode = 7'h38;
        endcase
    endfunction

    always_comb begin
        tick          = (cnt_q == CNT_LAST);
        boundary      = tick && (idx_q == '0);
        cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
        end
        if (boundary) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end

        stage_val_d    = stage_val_q;
        stage_dp_d     = stage_dp_q;
        stage_blank_d  = stage_blank_q;
        stage_blink_d  = stage_blink_q;
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        shadow_blink_d = shadow_blink_q;
        pending_d      = pending_q;
        if (update && boundary) begin
            // Fresh data at the boundary bypasses staging so it shows in the frame starting now.
            stage_val_d    = display_val;
            stage_dp_d     = dp_in;
            stage_blank_d  = blank_mask;
            stage_blink_d  = blink_mask;
            shadow_val_d   = display_val;
            shadow_dp_d    = dp_in;
            shadow_blank_d = blank_mask;
            shadow_blink_d = blink_mask;
            pending_d      = 1'b0;
        end else begin
            if (update) begin
                stage_val_d   = display_val;
                stage_dp_d    = dp_in;
                stage_blank_d = blank_mask;
                stage_blink_d = blink_mask;
                pending_d     = 1'b1;
            end
            if (boundary && pending_q) begin
                shadow_val_d   = stage_val_q;
                shadow_dp_d    = stage_dp_q;
                shadow_blank_d = stage_blank_q;
                shadow_blink_d = stage_blink_q;
                pending_d      = 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    always_comb begin
        logic run;
        lz_sup = '0;
        run    = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run       = run && (shadow_val_q[4*k +: 4] == 4'h0) && !shadow_dp_q[k];
            lz_sup[k] = run;
        end
    end
`else
    assign lz_sup = '0;
`endif

    always_comb begin
        nib        = shadow_val_q[{idx_q, 2'b00} +: 4];
        on_time    = (ON_W'(brightness) + ON_W'(1)) * ON_W'(STEP);
        lit        = !shadow_blank_q[idx_q] && !(shadow_blink_q[idx_q] && blink_phase_q) &&
                     ({1'b0, cnt_q} < on_time) && !lz_sup[idx_q];
        anodes_d   = '1;
        cathodes_d = 7'h7F;
        dp_d       = 1'b1;
        if (lit) begin
            anodes_d   = ~(NUM_DIGITS'(1) << idx_q);
            cathodes_d = seg_decode(nib);
            dp_d       = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt_q          <= '0;
            idx_q          <= IDX_LAST;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            pending_q      <= 1'b0;
            bnd_dly_q      <= 1'b0;
            stage_val_q    <= '0;
            stage_dp_q     <= '0;
            stage_blank_q  <= '0;
            stage_blink_q  <= '0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            shadow_blink_q <= '0;
            anodes_q       <= '1;
            cathodes_q     <= 7'h7F;
            dp_q           <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            pending_q      <= pending_d;
            // Two-stage delay lines the pulse up with the first registered output of the new slot.
            bnd_dly_q      <= boundary;
            frame_done_q   <= bnd_dly_q;
            stage_val_q    <= stage_val_d;
            stage_dp_q     <= stage_dp_d;
            stage_blank_q  <= stage_blank_d;
            stage_blink_q  <= stage_blink_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_blink_q <= shadow_blink_d;
            anodes_q       <= anodes_d;
            cathodes_q     <= cathodes_d;
            dp_q           <= dp_d;
        end
    end

    assign anodes       = anodes_q;
    assign cathodes_out = cathodes_q;
    assign dp_out       = dp_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl: 4 digits, 16-cycle slots, 2-bit brightness, 2-frame blink.
module tb_seven_segment_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] display_val;
    logic [3:0]  dp_in, blank_mask, blink_mask;
    logic [1:0]  brightness;
    logic        update;
    logic [3:0]  anodes;
    logic [6:0]  cathodes_out;
    logic        dp_out, frame_done;

    int total = 0;
    int bad   = 0;

    // Expected-frame description: cathode pattern per digit, dark digits, dp digits, lit cycles per slot.
    logic [6:0] ecat [4];
    logic [3:0] dk, dpm;
    int         onc;
    logic [3:0] ean;
    logic [6:0] ec;
    logic       edp, efd;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [3:0] ZDARK = 4'b1110;
`else
    localparam logic [3:0] ZDARK = 4'b0000;
`endif

    seven_segment_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(16), .BRIGHT_W(2), .BLINK_FRAMES(2)
    ) dut (
        .system_clock(clk), .cpu_rst_n(rst_n), .display_val(display_val), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .brightness(brightness), .update(update),
        .anodes(anodes), .cathodes_out(cathodes_out), .dp_out(dp_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void calc_exp(input int s, input int c, input bit fd_here);
        int d;
        bit lit;
        d   = 3 - s;
        lit = (c < onc) && !dk[d];
        ean = lit ? ~(4'b0001 << d) : 4'hF;
        ec  = lit ? ecat[d] : 7'h7F;
        edp = lit ? ~dpm[d] : 1'b1;
        efd = fd_here && (s == 0) && (c == 0);
    endfunction

    function automatic void set_cat(input logic [6:0] c3, c2, c1, c0);
        ecat[3] = c3; ecat[2] = c2; ecat[1] = c1; ecat[0] = c0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({anodes, cathodes_out, dp_out, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", {anodes, cathodes_out, dp_out, frame_done},
                     {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame0_update();
        set_cat(7'h01, 7'h01, 7'h01, 7'h01);
        dk = ZDARK; dpm = 4'h0; onc = 16;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 16; c++) begin
                calc_exp(s, c, 1'b0);
                total++;
                if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                    bad++;
                    $display("FAIL frame0 s=%0d c=%0d got=%h want=%h", s, c,
                             {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                end
                update = (s == 1 && c == 3);
                if (update) display_val = 16'h1234;
                step();
            end
    endtask

    task automatic test_basic();
        set_cat(7'h4F, 7'h12, 7'h06, 7'h4C);
        dk = 4'h0;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 16; c++) begin
                calc_exp(s, c, 1'b1);
                total++;
                if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                    bad++;
                    $display("FAIL basic_1234 s=%0d c=%0d got=%h want=%h", s, c,
                             {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                end
                step();
            end
    endtask

    task automatic test_dim();
        brightness = 2'd0;
        onc = 4;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 16; c++) begin
                calc_exp(s, c, 1'b1);
                total++;
                if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                    bad++;
                    $display("FAIL dim s=%0d c=%0d got=%h want=%h", s, c,
                             {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                end
                step();
            end
        brightness = 2'd3;
        onc = 16;
    endtask

    task automatic test_midframe();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) set_cat(7'h4F, 7'h12, 7'h06, 7'h4C);
            else        set_cat(7'h08, 7'h60, 7'h31, 7'h42);
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 16; c++) begin
                    calc_exp(s, c, 1'b1);
                    total++;
                    if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                        bad++;
                        $display("FAIL midframe f=%0d s=%0d c=%0d got=%h want=%h", f, s, c,
                                 {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                    end
                    update = (f == 0 && s == 1 && c == 4);
                    if (update) display_val = 16'hABCD;
                    step();
                end
        end
    endtask

    task automatic test_coincident();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin set_cat(7'h08, 7'h60, 7'h31, 7'h42); dk = 4'h0; end
            else        begin set_cat(7'h24, 7'h20, 7'h0F, 7'h00); dk = 4'b0010; end
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 16; c++) begin
                    calc_exp(s, c, 1'b1);
                    total++;
                    if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                        bad++;
                        $display("FAIL coincident f=%0d s=%0d c=%0d got=%h want=%h", f, s, c,
                                 {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                    end
                    // (3,14) sample: the next edge is the boundary tick itself.
                    update = (f == 0 && s == 3 && c == 14);
                    if (update) begin
                        display_val = 16'h5678;
                        blank_mask  = 4'b0010;
                    end
                    step();
                end
        end
    endtask

    task automatic test_blink_dp();
        for (int f = 7; f < 12; f++) begin
            if (f == 7) begin dk = 4'b0010; dpm = 4'h0; end
            else begin
                dk  = (((f / 2) % 2) == 1) ? 4'b0001 : 4'b0000;
                dpm = 4'b0100;
            end
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 16; c++) begin
                    calc_exp(s, c, 1'b1);
                    total++;
                    if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                        bad++;
                        $display("FAIL blink_dp f=%0d s=%0d c=%0d got=%h want=%h", f, s, c,
                                 {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                    end
                    update = (f == 7 && s == 0 && c == 2);
                    if (update) begin
                        blank_mask = 4'h0;
                        blink_mask = 4'b0001;
                        dp_in      = 4'b0100;
                    end
                    step();
                end
        end
    endtask

    task automatic test_reset_mid();
        int s, c;
        dk = 4'h0;
        for (int g = 0; g < 37; g++) begin
            s = g / 16;
            c = g % 16;
            calc_exp(s, c, 1'b1);
            total++;
            if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                bad++;
                $display("FAIL pre_reset s=%0d c=%0d got=%h want=%h", s, c,
                         {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
            end
            update = (g == 8);
            if (update) begin
                display_val = 16'h9999;
                blink_mask  = 4'h0;
                dp_in       = 4'h0;
            end
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({anodes, cathodes_out, dp_out, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", {anodes, cathodes_out, dp_out, frame_done},
                     {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        set_cat(7'h01, 7'h01, 7'h01, 7'h01);
        dk = ZDARK; dpm = 4'h0;
        for (int f = 0; f < 2; f++)
            for (int s2 = 0; s2 < 4; s2++)
                for (int c2 = 0; c2 < 16; c2++) begin
                    calc_exp(s2, c2, f == 1);
                    total++;
                    if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                        bad++;
                        $display("FAIL post_reset f=%0d s=%0d c=%0d got=%h want=%h", f, s2, c2,
                                 {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                    end
                    step();
                end
    endtask

`ifdef SEG7_LZ_BLANK_EN
    task automatic test_lz();
        for (int f = 0; f < 3; f++) begin
            if (f == 0)      begin set_cat(7'h01, 7'h01, 7'h01, 7'h01); dk = 4'b1110; dpm = 4'h0; end
            else if (f == 1) begin set_cat(7'h01, 7'h01, 7'h4C, 7'h01); dk = 4'b1100; dpm = 4'h0; end
            else             begin dk = 4'b0000; dpm = 4'b1000; end
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 16; c++) begin
                    calc_exp(s, c, 1'b1);
                    total++;
                    if ({anodes, cathodes_out, dp_out, frame_done} !== {ean, ec, edp, efd}) begin
                        bad++;
                        $display("FAIL lz f=%0d s=%0d c=%0d got=%h want=%h", f, s, c,
                                 {anodes, cathodes_out, dp_out, frame_done}, {ean, ec, edp, efd});
                    end
                    update = (f < 2 && s == 0 && c == 1);
                    if (update) begin
                        display_val = 16'h0040;
                        dp_in       = (f == 1) ? 4'b1000 : 4'b0000;
                    end
                    step();
                end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; display_val = '0; dp_in = '0; blank_mask = '0; blink_mask = '0;
        brightness = 2'd3; update = 1'b0;
        test_reset();
        test_frame0_update();
        test_basic();
        test_dim();
        test_midframe();
        test_coincident();
        test_blink_dp();
        test_reset_mid();
`ifdef SEG7_LZ_BLANK_EN
        test_lz();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
